// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int WIDTH_DEFAULT = 8;
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
// The op field exists only when SERIAL_ADDER_SUB_EN is defined.
//
// Handshake: a transfer happens on the rising clk edge where valid && ready
// are both high. A source holds valid and its payload stable until that edge.
// A sink may change ready at any time. Neither side waits for the other's
// valid/ready before asserting its own.
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic             op;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output in_valid, a, b, op, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, op, out_ready,
                    output in_ready, out_valid, sum, cout);
`else
    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl_adder_bit_cell.sv
// One-bit full adder built from two half-adder stages and an OR.
module adder_bit_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p1;
    logic g1;
    logic g2;

    assign p1   = a ^ b;
    assign g1   = a & b;
    assign s    = p1 ^ cin;
    assign g2   = p1 & cin;
    assign cout = g1 | g2;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full-adder cell, LSB first, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add the op input (op=1 computes a-b mod 2^WIDTH).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_adder_ctrl_if.slave   bus,
    output logic                 busy,
    output state_t               dbg_state
);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             out_valid_r;
    logic             in_ready_r;
    logic             cell_s;
    logic             cell_c;
    logic             load_op;

`ifdef SERIAL_ADDER_SUB_EN
    assign load_op = bus.op;
`else
    assign load_op = 1'b0;
`endif

    adder_bit_cell u_cell (
        .a    (ra[0]),
        .b    (rb[0]),
        .cin  (carry),
        .s    (cell_s),
        .cout (cell_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            carry       <= 1'b0;
            ra          <= '0;
            rb          <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        // Subtract is a + ~b + 1: invert b once here and seed the carry.
                        ra         <= bus.a;
                        rb         <= load_op ? ~bus.b : bus.b;
                        carry      <= load_op;
                        idx        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum_r <= {cell_s, sum_r[WIDTH-1:1]};
                    ra    <= ra >> 1;
                    rb    <= rb >> 1;
                    carry <= cell_c;
                    if (idx == LAST_IDX) begin
                        idx         <= '0;
                        cout_r      <= cell_c;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_valid_r && bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign busy          = (state != IDLE);
    assign dbg_state     = state;
endmodule
